// File: rtl/store_narrow_unit.sv
// Store narrowing unit: turns SB/SH/SW stores into byte-enabled, lane-replicated word writes.
// Legal stores are buffered in a small FIFO and drained to data memory over a req/ack handshake.
module store_narrow_unit #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_op,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              st_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    // Handshakes: a store transfers on the edge where st_valid && st_ready; a buffered
    // write retires on the edge where mem_req && mem_ack. Neither ready depends on its valid.

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [3:0]        be_q    [DEPTH];
    logic [31:0]       wdata_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        legal;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        legal     = 1'b0;
        dec_be    = 4'b0000;
        dec_wdata = 32'h0;
        case (st_op)
            OP_SW: begin
                legal     = (st_addr[1:0] == 2'b00);
                dec_be    = 4'b1111;
                dec_wdata = st_data;
            end
            OP_SH: begin
                legal     = !st_addr[0];
                dec_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata = {2{st_data[15:0]}};
            end
            OP_SB: begin
                legal     = 1'b1;
                dec_be    = 4'b0001 << st_addr[1:0];
                dec_wdata = {4{st_data[7:0]}};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign st_ready = (count != CNT_W'(DEPTH)) && reset_n;
    assign accept   = st_valid && st_ready;
    assign push     = accept && legal;
    assign mem_req  = (count != '0);
    assign pop      = mem_req && mem_ack;
    assign idle     = (count == '0);

    // Empty buffer drives all-zero write fields so the memory port never sees stale data.
    assign mem_addr  = mem_req ? addr_q[rd_ptr]  : '0;
    assign mem_be    = mem_req ? be_q[rd_ptr]    : 4'b0000;
    assign mem_wdata = mem_req ? wdata_q[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr]  <= {st_addr[ADDR_W-1:2], 2'b00};
            be_q[wr_ptr]    <= dec_be;
            wdata_q[wr_ptr] <= dec_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            st_err   <= 1'b0;
            err_addr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Rejected stores still complete their handshake; only the error pulse records them.
            st_err <= accept && !legal;
            if (accept && !legal) begin
                err_addr <= st_addr;
            end
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: a reference model fills an expected-write queue
// as stores are driven, and every drained write is compared against the queue head.
module tb_store_narrow_unit;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset_n;
    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_op;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              st_err;
    logic [ADDR_W-1:0] err_addr;
    logic              idle;

    store_narrow_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .st_err    (st_err),
        .err_addr  (err_addr),
        .idle      (idle)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {word addr[31:0], be[3:0], wdata[31:0]}
    logic [67:0] exp_q[$];
    logic        exp_err;
    logic [31:0] exp_err_addr;
    int          tests_run;
    int          tests_failed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_store(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] d, output logic [67:0] e);
        logic        ok;
        logic [3:0]  be;
        logic [31:0] w;
        ok = 1'b0;
        be = 4'b0000;
        w  = 32'h0;
        case (op)
            2'b10: begin
                ok = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    be[k]        = (a[1:0] == k[1:0]);
                    w[8*k +: 8]  = d[7:0];
                end
            end
            2'b01: begin
                ok = (a[0] == 1'b0);
                be = a[1] ? 4'b1100 : 4'b0011;
                w  = {d[15:0], d[15:0]};
            end
            2'b00: begin
                ok = (a[1:0] == 2'b00);
                be = 4'b1111;
                w  = d;
            end
            default: ok = 1'b0;
        endcase
        e = {a[31:2], 2'b00, be, w};
        return ok;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, then cross the rising edge.
    task automatic step();
        logic        m_ready;
        logic        m_pop;
        logic        m_accept;
        logic        ok;
        logic [67:0] e;
        @(negedge clk);
        check("idle", idle, exp_q.size() == 0);
        check("st_ready", st_ready, reset_n && (exp_q.size() < DEPTH));
        check("mem_req", mem_req, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("mem_addr", mem_addr, exp_q[0][67:36]);
            check("mem_be", {28'h0, mem_be}, {28'h0, exp_q[0][35:32]});
            check("mem_wdata", mem_wdata, exp_q[0][31:0]);
        end else begin
            check("empty_addr", mem_addr, 32'h0);
            check("empty_be", {28'h0, mem_be}, 32'h0);
            check("empty_wdata", mem_wdata, 32'h0);
        end
        check("st_err", st_err, exp_err);
        check("err_addr", err_addr, exp_err_addr);

        m_ready  = reset_n && (exp_q.size() < DEPTH);
        m_pop    = (exp_q.size() != 0) && mem_ack;
        m_accept = st_valid && m_ready;
        if (!reset_n) begin
            exp_q.delete();
            exp_err      = 1'b0;
            exp_err_addr = 32'h0;
        end else begin
            if (m_pop) begin
                void'(exp_q.pop_front());
            end
            exp_err = 1'b0;
            if (m_accept) begin
                ok = model_store(st_op, st_addr, st_data, e);
                if (ok) begin
                    exp_q.push_back(e);
                end else begin
                    exp_err      = 1'b1;
                    exp_err_addr = st_addr;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic ack);
        st_valid = v;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
        mem_ack  = ack;
        step();
    endtask

    task automatic idle_cycle(input logic ack);
        drive(1'b0, 2'b00, 32'h0, 32'h0, ack);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_err      = 1'b0;
        exp_err_addr = 32'h0;
        reset_n  = 1'b0;
        st_valid = 1'b0;
        st_op    = 2'b00;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        mem_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step();
        reset_n = 1'b1;

        // SB to byte lane 3
        drive(1'b1, 2'b10, 32'h0000_0103, 32'hAABB_CCDD, 1'b0);
        check("t1_req", mem_req, 1'b1);
        check("t1_addr", mem_addr, 32'h0000_0100);
        check("t1_be", {28'h0, mem_be}, 32'h8);
        check("t1_wdata", mem_wdata, 32'hDDDD_DDDD);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // SH then SW with memory stalled: buffer fills, head held
        drive(1'b1, 2'b01, 32'h0000_0202, 32'h0000_1234, 1'b0);
        drive(1'b1, 2'b00, 32'h0000_0204, 32'hCAFE_F00D, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("t2_be", {28'h0, mem_be}, 32'hC);
        check("t2_wdata", mem_wdata, 32'h1234_1234);
        check("t2_full", st_ready, 1'b0);
        idle_cycle(1'b1);
        check("t2_second_addr", mem_addr, 32'h0000_0204);
        idle_cycle(1'b1);
        check("t2_idle", idle, 1'b1);

        // misaligned SW rejected
        drive(1'b1, 2'b00, 32'h0000_0301, 32'h1111_2222, 1'b0);
        check("t3_err", st_err, 1'b1);
        check("t3_err_addr", err_addr, 32'h0000_0301);
        check("t3_req", mem_req, 1'b0);
        idle_cycle(1'b0);
        check("t3_err_pulse", st_err, 1'b0);
        drive(1'b1, 2'b11, 32'h0000_0310, 32'h0, 1'b0);
        drive(1'b1, 2'b01, 32'h0000_0313, 32'h0, 1'b0);

        // full buffer with ack and a waiting store in the same cycle
        drive(1'b1, 2'b00, 32'h0000_0400, 32'h0404_0404, 1'b0);
        drive(1'b1, 2'b00, 32'h0000_0404, 32'h0808_0808, 1'b0);
        drive(1'b1, 2'b10, 32'h0000_0409, 32'h0000_005A, 1'b1);
        drive(1'b1, 2'b10, 32'h0000_0409, 32'h0000_005A, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // simultaneous push and pop with one entry buffered
        drive(1'b1, 2'b00, 32'h0000_0500, 32'h5555_0000, 1'b0);
        drive(1'b1, 2'b01, 32'h0000_0506, 32'h0000_BEEF, 1'b1);
        check("t5_head_addr", mem_addr, 32'h0000_0504);
        check("t5_head_be", {28'h0, mem_be}, 32'hC);
        check("t5_ready", st_ready, 1'b1);
        idle_cycle(1'b1);

        // reset while two writes are pending
        drive(1'b1, 2'b00, 32'h0000_0600, 32'h6666_6666, 1'b0);
        drive(1'b1, 2'b00, 32'h0000_0604, 32'h7777_7777, 1'b0);
        reset_n = 1'b0;
        idle_cycle(1'b0);
        reset_n = 1'b1;
        check("t6_req", mem_req, 1'b0);
        check("t6_idle", idle, 1'b1);
        check("t6_err", st_err, 1'b0);
        repeat (3) idle_cycle(1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  {20'h0, 12'($urandom)}, $urandom, $urandom_range(0, 2) != 0);
        end
        repeat (4) idle_cycle(1'b1);
        check("final_idle", idle, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
